// File: rtl/fosfor_present_pkg.sv
// Shared constants for the PRESENT-80 pin-interface accelerator:
// bus phases, command codes, register map and the PRESENT S-box.
package fosfor_present_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_LOW  = 2'd1,
    PH_HIGH = 2'd2,
    PH_CMD  = 2'd3
  } phase_t;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_BUSY = 1'b1
  } fsm_t;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_LATCH = 4'd1;
  localparam logic [3:0] CMD_WRITE = 4'd2;
  localparam logic [3:0] CMD_START = 4'd3;

  localparam int unsigned STATE_BYTES   = 8;
  localparam int unsigned KEY_BYTES     = 10;
  localparam int unsigned KEY_OFFSET    = 8;
  localparam logic [7:0]  TEST_REG_ADDR = 8'h20;
  localparam int unsigned NUM_ROUNDS    = 31;

  // Nibble x of SBOX holds S(x): C 5 6 B 9 0 A D 3 E F 8 4 7 1 2
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/fosfor_present_round.sv
// One combinational PRESENT-80 round (addRoundKey, sBoxLayer, pLayer)
// together with the matching key-schedule step.
module fosfor_present_round
  import fosfor_present_pkg::*;
(
  input  logic [63:0] state_i,
  input  logic [79:0] key_i,
  input  logic [4:0]  ctr_i,
  output logic [63:0] state_o,
  output logic [79:0] key_o
);

  logic [63:0] mixed;
  logic [63:0] subst;
  logic [79:0] rot;

  assign mixed = state_i ^ key_i[79:16];

  // Sixteen parallel S-boxes
  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign subst[4*gi +: 4] = sbox4(mixed[4*gi +: 4]);
  end

  // Bit permutation: bit i goes to (16*i) mod 63, bit 63 stays put
  for (genvar gi = 0; gi < 64; gi++) begin : g_perm
    localparam int DST = (gi == 63) ? 63 : (gi * 16) % 63;
    assign state_o[DST] = subst[gi];
  end

  // Rotate left by 61 is a rotate right by 19
  assign rot = {key_i[18:0], key_i[79:19]};

  // Key schedule: S-box on the top nibble, round counter folded into [19:15]
  always_comb begin
    key_o          = rot;
    key_o[79:76]   = sbox4(rot[79:76]);
    key_o[19:15]   = rot[19:15] ^ ctr_i;
  end

endmodule

// File: rtl/fosfor_present_top.sv
// PRESENT-80 accelerator behind a two-byte pin interface.
// io_in = {DataIn[3:0], Address[1:0], Reset, Clk}; io_out is registered.
// Optional feature macro: FOSFOR_TEST_REG_EN adds a scratch register at 0x20.
module fosfor_present_top
  import fosfor_present_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       srst;
  phase_t     phase;
  logic [3:0] din;

  assign clk   = io_in[0];
  assign srst  = io_in[1];
  assign phase = phase_t'(io_in[3:2]);
  assign din   = io_in[7:4];

  logic [7:0]  d_q, d_d;
  logic [7:0]  a_q, a_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [79:0] wk_q, wk_d;
  logic [5:0]  ctr_q, ctr_d;
  fsm_t        fsm_q, fsm_d;
  logic [7:0]  io_out_q, io_out_d;
  logic [7:0]  rd_data;
`ifdef FOSFOR_TEST_REG_EN
  logic [7:0]  test_q, test_d;
`endif

  logic [63:0] round_state;
  logic [79:0] round_key;

  fosfor_present_round u_round (
    .state_i (state_q),
    .key_i   (wk_q),
    .ctr_i   (ctr_q[4:0]),
    .state_o (round_state),
    .key_o   (round_key)
  );

  // Register-file read mux addressed by the latched address
  always_comb begin
    rd_data = 8'h00;
    if (a_q < 8'(STATE_BYTES)) begin
      rd_data = state_q[{a_q[2:0], 3'b000} +: 8];
    end
    for (int i = 0; i < KEY_BYTES; i++) begin
      if (a_q == 8'(KEY_OFFSET + i)) rd_data = key_q[8*i +: 8];
    end
`ifdef FOSFOR_TEST_REG_EN
    if (a_q == TEST_REG_ADDR) rd_data = test_q;
`endif
  end

  // Bus decode, command execution and round sequencing
  always_comb begin
    d_d      = d_q;
    a_d      = a_q;
    state_d  = state_q;
    key_d    = key_q;
    wk_d     = wk_q;
    ctr_d    = ctr_q;
    fsm_d    = fsm_q;
`ifdef FOSFOR_TEST_REG_EN
    test_d   = test_q;
`endif
    io_out_d = (phase == PH_LOW) ? rd_data : {7'b0, fsm_q == FSM_IDLE};

    // Counter 1..31 runs rounds; at 32 the last round key is added
    if (fsm_q == FSM_BUSY) begin
      if (ctr_q == 6'(NUM_ROUNDS + 1)) begin
        state_d = state_q ^ wk_q[79:16];
        fsm_d   = FSM_IDLE;
      end else begin
        state_d = round_state;
        wk_d    = round_key;
        ctr_d   = ctr_q + 6'd1;
      end
    end

    case (phase)
      PH_LOW:  d_d[3:0] = din;
      PH_HIGH: d_d[7:4] = din;
      PH_CMD: begin
        case (din)
          CMD_LATCH: a_d = d_q;
          CMD_WRITE: begin
            if (fsm_q == FSM_IDLE) begin
              if (a_q < 8'(STATE_BYTES)) state_d[{a_q[2:0], 3'b000} +: 8] = d_q;
              for (int i = 0; i < KEY_BYTES; i++) begin
                if (a_q == 8'(KEY_OFFSET + i)) key_d[8*i +: 8] = d_q;
              end
            end
`ifdef FOSFOR_TEST_REG_EN
            if (a_q == TEST_REG_ADDR) test_d = d_q;
`endif
          end
          CMD_START: begin
            if (fsm_q == FSM_IDLE) begin
              fsm_d = FSM_BUSY;
              wk_d  = key_q;
              ctr_d = 6'd1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (srst) begin
      d_q      <= '0;
      a_q      <= '0;
      state_q  <= '0;
      key_q    <= '0;
      wk_q     <= '0;
      ctr_q    <= '0;
      fsm_q    <= FSM_IDLE;
      io_out_q <= '0;
`ifdef FOSFOR_TEST_REG_EN
      test_q   <= '0;
`endif
    end else begin
      d_q      <= d_d;
      a_q      <= a_d;
      state_q  <= state_d;
      key_q    <= key_d;
      wk_q     <= wk_d;
      ctr_q    <= ctr_d;
      fsm_q    <= fsm_d;
      io_out_q <= io_out_d;
`ifdef FOSFOR_TEST_REG_EN
      test_q   <= test_d;
`endif
    end
  end

  assign io_out = io_out_q;

endmodule

// File: tb/tb_fosfor_present_top.sv
// Directed bench for fosfor_present_top using the PRESENT-80 reference vectors.
module tb_fosfor_present_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [3:0] din = 4'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] P_IDLE = 2'd0, P_LOW = 2'd1, P_HIGH = 2'd2, P_CMD = 2'd3;
  localparam logic [63:0] CT_ZERO = 64'h5579C1387B228445;
  localparam logic [63:0] CT_ONES = 64'h3333DCD3213210D2;

  assign io_in = {din, addr, rst, clk};

  fosfor_present_top dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus edge, then fall back to IDLE so the phase is not resampled
  task automatic bus(input logic [1:0] ph, input logic [3:0] dn);
    @(negedge clk);
    addr = ph;
    din  = dn;
    @(posedge clk);
    #1;
    addr = P_IDLE;
    din  = 4'd0;
  endtask

  task automatic latch(input logic [7:0] a);
    bus(P_LOW, a[3:0]);
    bus(P_HIGH, a[7:4]);
    bus(P_CMD, 4'd1);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] v);
    latch(a);
    bus(P_LOW, v[3:0]);
    bus(P_HIGH, v[7:4]);
    bus(P_CMD, 4'd2);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
    latch(a);
    bus(P_LOW, 4'd0);
    v = io_out;
  endtask

  task automatic load(input logic [79:0] key, input logic [63:0] pt);
    for (int i = 0; i < 10; i++) write_reg(8'(8 + i), key[8*i +: 8]);
    for (int i = 0; i < 8; i++) write_reg(8'(i), pt[8*i +: 8]);
  endtask

  task automatic read_state(output logic [63:0] s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      read_reg(8'(i), b);
      s[8*i +: 8] = b;
    end
  endtask

  // Issue START, confirm busy, then poll status with a bounded loop
  task automatic start_and_wait(input string tag);
    int k;
    bus(P_CMD, 4'd3);
    bus(P_IDLE, 4'd0);
    chk({tag, "_busy"}, {56'd0, io_out}, 64'h00);
    k = 1;
    while (k < 40 && io_out !== 8'h01) begin
      bus(P_IDLE, 4'd0);
      k++;
    end
    chk({tag, "_latency_ok"}, {63'd0, k <= 33}, 64'd1);
    chk({tag, "_ready"}, {56'd0, io_out}, 64'h01);
    $display("[TB] %s: ready after %0d status polls", tag, k);
  endtask

  initial begin
    logic [63:0] ct;
    logic [7:0]  b;

    // Reset
    @(posedge clk); @(posedge clk); #1;
    chk("reset_io_out", {56'd0, io_out}, 64'h00);
    @(negedge clk); rst = 1'b0;
    bus(P_IDLE, 4'd0);
    bus(P_IDLE, 4'd0);
    chk("idle_status", {56'd0, io_out}, 64'h01);

    // Unmapped address
    read_reg(8'h15, b);
    chk("unmapped_read", {56'd0, b}, 64'h00);

    // All-zero vector
    load(80'h0, 64'h0);
    read_reg(8'd0, b);
    chk("pt_readback", {56'd0, b}, 64'h00);
    start_and_wait("zero");
    read_state(ct);
    chk("ct_zero", ct, CT_ZERO);
    read_reg(8'd0, b);
    chk("ct_zero_byte0", {56'd0, b}, 64'h45);

    // All-ones vector
    load({80{1'b1}}, {64{1'b1}});
    start_and_wait("ones");
    read_state(ct);
    chk("ct_ones", ct, CT_ONES);
    read_reg(8'd17, b);
    chk("key_byte9_kept", {56'd0, b}, 64'hFF);

    // Busy rules: second START and writes while busy are ignored
    load(80'h0, 64'h0);
    bus(P_CMD, 4'd3);
    bus(P_CMD, 4'd3);
    write_reg(8'd0, 8'hAA);
    write_reg(8'd8, 8'hFF);
    for (int i = 0; i < 40; i++) bus(P_IDLE, 4'd0);
    chk("busy_done_status", {56'd0, io_out}, 64'h01);
    read_state(ct);
    chk("ct_busy_rules", ct, CT_ZERO);
    read_reg(8'd8, b);
    chk("key_write_ignored", {56'd0, b}, 64'h00);

    // Test register
    write_reg(8'h20, 8'hA5);
    read_reg(8'h20, b);
`ifdef FOSFOR_TEST_REG_EN
    chk("test_reg", {56'd0, b}, 64'hA5);
`else
    chk("test_reg", {56'd0, b}, 64'h00);
`endif

    // Reset in the middle of an encryption
    load({80{1'b1}}, {64{1'b1}});
    bus(P_CMD, 4'd3);
    for (int i = 0; i < 10; i++) bus(P_IDLE, 4'd0);
    chk("mid_busy", {56'd0, io_out}, 64'h00);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_io_out", {56'd0, io_out}, 64'h00);
    @(negedge clk); rst = 1'b0;
    bus(P_IDLE, 4'd0);
    chk("mid_reset_status", {56'd0, io_out}, 64'h01);
    read_state(ct);
    chk("mid_reset_state", ct, 64'h0);
    read_reg(8'd12, b);
    chk("mid_reset_key", {56'd0, b}, 64'h00);
    bus(P_IDLE, 4'd0);
    chk("mid_reset_idle_after", {56'd0, io_out}, 64'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
